quant_stream: RTL

Multi-lane, pipelined requantiser for the fixed-point math library: it converts CH signed accumulator words to OW-bit quantised values through multiply, round, shift, zero-point add and clamp. It is the parametrised successor of the single-lane quantiser. It adds per-lane scale, shift and zero-point, selectable rounding, signed or unsigned output, a valid/ready stream interface with back-pressure, and saturation reporting. It sits between the MAC/accumulator array and the activation write-back buffer.

---
 rtl/quant_pkg.sv | 26 ++
 rtl/quant_lane.sv | 105 ++++++++++
 rtl/quant_stream.sv | 92 +++++++++
 3 files changed

// File: rtl/quant_pkg.sv
// Shared definitions for the quant_stream requantiser.
//   RND_TRUNC / RND_HALF_UP : encodings of the i_round select
//   clamp_t / clamp_bounds  : output clamp range derived from OW and OSIGNED
package quant_pkg;

  localparam logic RND_TRUNC   = 1'b0;
  localparam logic RND_HALF_UP = 1'b1;

  typedef struct packed {
    logic signed [31:0] lo;
    logic signed [31:0] hi;
  } clamp_t;

  function automatic clamp_t clamp_bounds(input int ow, input bit osigned);
    clamp_t b;
    if (osigned) begin
      b.lo = -(32'sd1 <<< (ow - 1));
      b.hi = (32'sd1 <<< (ow - 1)) - 32'sd1;
    end else begin
      b.lo = 32'sd0;
      b.hi = (32'sd1 <<< ow) - 32'sd1;
    end
    return b;
  endfunction

endpackage

// File: rtl/quant_lane.sv
// Single-lane requantiser datapath: input capture, multiply, round/shift,
// zero-point add and clamp. Every register advances only when en=1.
//   clock, reset : clock and synchronous active-high reset (output stage only)
//   en           : global pipeline enable
//   data, scale  : signed accumulator and scale
//   shift        : unsigned right-shift amount
//   zp           : zero point (signed when OSIGNED=1)
//   rnd          : 1 = round-half-up, 0 = floor
//   q, sat       : quantised result and clamp flag
module quant_lane
  import quant_pkg::*;
#(
  parameter int IW      = 18,
  parameter int SW      = 16,
  parameter int SHW     = 5,
  parameter int OW      = 8,
  parameter int OSIGNED = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic signed [IW-1:0] data,
  input  logic signed [SW-1:0] scale,
  input  logic [SHW-1:0]       shift,
  input  logic [OW-1:0]        zp,
  input  logic                 rnd,
  output logic [OW-1:0]        q,
  output logic                 sat
);

  localparam int PW = IW + SW;
  localparam int RW = PW + 1;
  localparam int ZW = PW + 2;
  localparam clamp_t BND = clamp_bounds(OW, OSIGNED != 0);
  localparam logic signed [ZW-1:0] LO = ZW'(BND.lo);
  localparam logic signed [ZW-1:0] HI = ZW'(BND.hi);

  function automatic logic signed [RW-1:0] round_shift(
    input logic signed [PW-1:0] p,
    input logic [SHW-1:0]       sh,
    input logic                 r
  );
    logic signed [RW-1:0] v;
    // Shifting out every product bit leaves only the sign.
    if (32'(sh) >= PW) return p[PW-1] ? '1 : '0;
    v = RW'(p);
    if (r == RND_HALF_UP && sh != '0) v = v + (RW'(1) << (sh - SHW'(1)));
    return v >>> sh;
  endfunction

  function automatic logic signed [ZW-1:0] zp_ext(input logic [OW-1:0] z);
    if (OSIGNED != 0) return ZW'($signed(z));
    return $signed(ZW'(z));
  endfunction

  // Returns {clamped, value}.
  function automatic logic [OW:0] clamp_q(input logic signed [ZW-1:0] v);
    if (v < LO) return {1'b1, LO[OW-1:0]};
    if (v > HI) return {1'b1, HI[OW-1:0]};
    return {1'b0, v[OW-1:0]};
  endfunction

  logic signed [IW-1:0] data_p0;
  logic signed [SW-1:0] scale_p0;
  logic [SHW-1:0]       shift_p0, shift_p1;
  logic [OW-1:0]        zp_p0, zp_p1, zp_p2;
  logic                 rnd_p0, rnd_p1;
  logic signed [PW-1:0] prod_p1;
  logic signed [RW-1:0] shr_p2;
  logic [OW-1:0]        q_p3;
  logic                 sat_p3;

  always_ff @(posedge clock) begin
    if (en) begin
      // p0: beat capture
      data_p0  <= data;
      scale_p0 <= scale;
      shift_p0 <= shift;
      zp_p0    <= zp;
      rnd_p0   <= rnd;
      // p1: full-precision product
      prod_p1  <= PW'(data_p0) * PW'(scale_p0);
      shift_p1 <= shift_p0;
      zp_p1    <= zp_p0;
      rnd_p1   <= rnd_p0;
      // p2: round and arithmetic shift
      shr_p2   <= round_shift(prod_p1, shift_p1, rnd_p1);
      zp_p2    <= zp_p1;
    end
  end

  // p3: zero-point add and clamp; cleared by reset so o_data reads 0
  always_ff @(posedge clock) begin
    if (reset) begin
      q_p3   <= '0;
      sat_p3 <= 1'b0;
    end else if (en) begin
      {sat_p3, q_p3} <= clamp_q(ZW'(shr_p2) + zp_ext(zp_p2));
    end
  end

  assign q   = q_p3;
  assign sat = sat_p3;

endmodule

// File: rtl/quant_stream.sv
// Multi-lane pipelined requantiser with valid/ready handshake.
//   clock, reset     : clock, synchronous active-high reset
//   i_valid/i_ready  : input handshake (i_ready = !o_valid || o_ready)
//   i_data, i_scale, i_shift, i_zp : per-lane fields, lane k in slice k
//   i_round          : 1 = round-half-up, 0 = truncate
//   o_valid/o_ready  : output handshake
//   o_data, o_sat    : per-lane results and clamp flags
//   sat_cnt          : saturating count of clamped lane-results transferred
module quant_stream
  import quant_pkg::*;
#(
  parameter int IW      = 18,
  parameter int SW      = 16,
  parameter int SHW     = 5,
  parameter int OW      = 8,
  parameter int CH      = 4,
  parameter int OSIGNED = 0,
  parameter int CW      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [CH*IW-1:0]  i_data,
  input  logic [CH*SW-1:0]  i_scale,
  input  logic [CH*SHW-1:0] i_shift,
  input  logic [CH*OW-1:0]  i_zp,
  input  logic              i_round,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [CH*OW-1:0]  o_data,
  output logic [CH-1:0]     o_sat,
  output logic [CW-1:0]     sat_cnt
);

  function automatic logic [CW-1:0] sat_add(
    input logic [CW-1:0] cnt,
    input logic [CH-1:0] flags
  );
    logic [CW:0] sum;
    sum = {1'b0, cnt} + (CW+1)'($countones(flags));
    return sum[CW] ? '1 : sum[CW-1:0];
  endfunction

  logic en;
  logic vld_p0, vld_p1, vld_p2, vld_p3;

  // A stalled output freezes the whole pipeline, bubbles included.
  assign en      = !o_valid || o_ready;
  assign i_ready = en;
  assign o_valid = vld_p3;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else if (en) begin
      vld_p0 <= i_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sat_cnt <= '0;
    end else if (o_valid && o_ready) begin
      sat_cnt <= sat_add(sat_cnt, o_sat);
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_lane
    quant_lane #(
      .IW(IW), .SW(SW), .SHW(SHW), .OW(OW), .OSIGNED(OSIGNED)
    ) u_lane (
      .clock (clock),
      .reset (reset),
      .en    (en),
      .data  ($signed(i_data[k*IW +: IW])),
      .scale ($signed(i_scale[k*SW +: SW])),
      .shift (i_shift[k*SHW +: SHW]),
      .zp    (i_zp[k*OW +: OW]),
      .rnd   (i_round),
      .q     (o_data[k*OW +: OW]),
      .sat   (o_sat[k])
    );
  end

endmodule
